// File: rtl/fetch_unit_pkg.sv
// Shared CPU package: the 16-bit machine word type, the default reset fetch
// address and the wrapping word increment used for PC arithmetic.
package fetch_unit_pkg;

  typedef logic [15:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 16'h0000;

  // PC increment, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  function automatic word_t word_inc(input word_t w);
    return w + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_hold.sv
// Stall hold buffer for the fetch output stage.
// The synchronous memory keeps returning data for the held address during a
// stall. The instruction that was on the output when the stall began is
// therefore captured here and replayed until the stall releases.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   redirect    : taken branch/jump; discards any held instruction
//   stall       : downstream not accepting; capture/hold the output
//   rdata       : instruction memory data currently on the output
//   valid_in    : output-stage valid (valid_b)
//   hold_inst   : captured instruction
//   hold_valid  : hold_inst overrides the memory data
module fetch_hold
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  redirect,
  input  logic  stall,
  input  word_t rdata,
  input  logic  valid_in,
  output word_t hold_inst,
  output logic  hold_valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_inst  <= 16'h0000;
      hold_valid <= 1'b0;
    end else if (redirect) begin
      hold_valid <= 1'b0;
    end else if (stall) begin
      // Capture only on the first stalled edge; later edges see memory data
      // for the next address and must not overwrite the held instruction.
      if (!hold_valid) begin
        hold_inst  <= rdata;
        hold_valid <= valid_in;
      end
    end else begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit for a synchronous (one-cycle latency) instruction
// memory. pc_a is the address presented to memory; pc_b/valid_b describe the
// instruction whose data is returning this cycle. A hold buffer keeps the
// output stable across stalls without dropping or duplicating instructions.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   stall        : IF/ID not accepting; hold current output
//   redirect     : restart fetch at redirect_pc (beats stall)
//   redirect_pc  : new fetch address
//   imem_addr    : memory address (pc_a, no path from imem_rdata)
//   imem_rdata   : memory data for the address presented last cycle
//   pcinc        : PC+1 of the instruction on inst
//   inst         : fetched instruction (0 when bubble)
//   inst_valid   : inst/pcinc hold a real instruction
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  output word_t imem_addr,
  input  word_t imem_rdata,
  output word_t pcinc,
  output word_t inst,
  output logic  inst_valid
);

  word_t pc_a;
  word_t pc_b;
  logic  valid_b;
  word_t hold_inst;
  logic  hold_valid;

  // Address stage (pc_a) -> output stage (pc_b, valid_b)
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_a    <= RESET_PC;
      pc_b    <= 16'h0000;
      valid_b <= 1'b0;
    end else if (redirect) begin
      pc_a    <= redirect_pc;
      valid_b <= 1'b0;
    end else if (!stall) begin
      pc_b    <= pc_a;
      valid_b <= 1'b1;
      pc_a    <= word_inc(pc_a);
    end
  end

  fetch_hold u_hold (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .stall      (stall),
    .rdata      (imem_rdata),
    .valid_in   (valid_b),
    .hold_inst  (hold_inst),
    .hold_valid (hold_valid)
  );

  // Output stage
  always_comb begin
    inst = 16'h0000;
    if (hold_valid) begin
      inst = hold_inst;
    end else if (valid_b) begin
      inst = imem_rdata;
    end
  end

  assign imem_addr  = pc_a;
  assign pcinc      = word_inc(pc_b);
  assign inst_valid = valid_b;

endmodule
